// File: rtl/tblink_rpc_clkctrl_mc.sv
// ---------------------------------------------------------------------------
// tblink_rpc_clkctrl_mc
//
// Multi-channel controlled-clock generator for tblink RPC gateways.
// Each of N_CLK channels produces a gated, divided clock from uclock. Each
// channel also keeps a rising-edge counter and a one-shot timer. Host commands
// arrive on the cmd_in toggle handshake. Timer expiries are queued as pending
// bits and posted one at a time on the cmd_out toggle handshake.
//
// Ports:
//   uclock          user clock
//   reset           asynchronous, active-high reset
//   cclock          controlled clocks, bit i = channel i
//   cmd_in          command code (1 GetTime, 2 SetTimer, 3 Release,
//                   4 SetDivisor, 5 Halt, 6 GetStatus)
//   cmd_in_params   [7:0] channel index, [8+TIMER_W-1:8] value
//   cmd_in_put_i    host toggles this to present a command
//   cmd_in_get_i    toggles when the command is consumed; response valid then
//   cmd_in_rsp      response data
//   cmd_in_rsp_sz   response size in bytes (0 or 8)
//   cmd_out         event code (1 = timer expired)
//   cmd_out_sz      event parameter size in bytes
//   cmd_out_params  event parameter (channel index)
//   cmd_out_put_i   toggles to post an event
//   cmd_out_get_i   host toggles this when it has accepted the event
// ---------------------------------------------------------------------------
module tblink_rpc_clkctrl_mc #(
  parameter int N_CLK         = 4,
  parameter int COUNT_W       = 64,
  parameter int TIMER_W       = 32,
  parameter bit HALT_ON_TIMER = 1'b1
) (
  input  logic             uclock,
  input  logic             reset,
  output logic [N_CLK-1:0] cclock,
  input  logic [7:0]       cmd_in,
  input  logic [63:0]      cmd_in_params,
  input  logic             cmd_in_put_i,
  output logic             cmd_in_get_i,
  output logic [63:0]      cmd_in_rsp,
  output logic [7:0]       cmd_in_rsp_sz,
  output logic [7:0]       cmd_out,
  output logic [7:0]       cmd_out_sz,
  output logic [7:0]       cmd_out_params,
  output logic             cmd_out_put_i,
  input  logic             cmd_out_get_i
);

  localparam logic [7:0] CMD_GET_TIME   = 8'd1;
  localparam logic [7:0] CMD_SET_TIMER  = 8'd2;
  localparam logic [7:0] CMD_RELEASE    = 8'd3;
  localparam logic [7:0] CMD_SET_DIV    = 8'd4;
  localparam logic [7:0] CMD_HALT       = 8'd5;
  localparam logic [7:0] CMD_GET_STATUS = 8'd6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } ev_state_t;

  // Per-channel state
  logic [N_CLK-1:0]   en_r;
  logic [N_CLK-1:0]   cclock_r;
  logic [N_CLK-1:0]   pending_r;
  logic [TIMER_W-1:0] div_r     [N_CLK];
  logic [TIMER_W-1:0] div_cnt_r [N_CLK];
  logic [TIMER_W-1:0] timer_r   [N_CLK];
  logic [COUNT_W-1:0] count_r   [N_CLK];

  // Command-side response registers
  logic               get_r;
  logic [63:0]        rsp_r;
  logic [7:0]         rsp_sz_r;

  // Event-side registers
  ev_state_t          state_r;
  ev_state_t          state_nxt_s;
  logic               put_r;
  logic [7:0]         ev_code_r;
  logic [7:0]         ev_sz_r;
  logic [7:0]         ev_param_r;

  // Command decode
  logic               cmd_hit_s;
  logic               ch_ok_s;
  logic [7:0]         ch_s;
  logic [TIMER_W-1:0] val_s;
  logic [N_CLK-1:0]   ch_sel_s;
  logic [COUNT_W-1:0] count_sel_s;
  logic [N_CLK-1:0]   set_timer_s;
  logic [N_CLK-1:0]   release_s;
  logic [N_CLK-1:0]   set_div_s;
  logic [N_CLK-1:0]   halt_s;
  logic [63:0]        rsp_nxt_s;
  logic [7:0]         rsp_sz_nxt_s;

  // Channel datapath
  logic [N_CLK-1:0]   tick_s;
  logic [N_CLK-1:0]   rise_s;
  logic [N_CLK-1:0]   expire_s;

  // Event posting
  logic               post_s;
  logic [7:0]         post_idx_s;
  logic [N_CLK-1:0]   lowest_s;
  logic [N_CLK-1:0]   post_clr_s;

  // Upper parameter bits carry nothing for this block.
  logic               unused_params_s;
  assign unused_params_s = ^cmd_in_params[63:8+TIMER_W];

  assign ch_s      = cmd_in_params[7:0];
  assign val_s     = cmd_in_params[8 +: TIMER_W];
  assign cmd_hit_s = cmd_in_put_i ^ get_r;
  assign ch_ok_s   = |ch_sel_s;

  // Channel one-hot select and AND-OR mux of the addressed counter
  always_comb begin
    ch_sel_s    = '0;
    count_sel_s = '0;
    for (int i = 0; i < N_CLK; i++) begin
      ch_sel_s[i] = (ch_s == 8'(i));
      count_sel_s = count_sel_s | (count_r[i] & {COUNT_W{ch_sel_s[i]}});
    end
  end

  // Command decode: per-channel strobes and the response for this command
  always_comb begin
    set_timer_s  = '0;
    release_s    = '0;
    set_div_s    = '0;
    halt_s       = '0;
    rsp_nxt_s    = '0;
    rsp_sz_nxt_s = 8'd0;
    if (cmd_hit_s && ch_ok_s) begin
      case (cmd_in)
        CMD_GET_TIME: begin
          rsp_nxt_s[COUNT_W-1:0] = count_sel_s;
          rsp_sz_nxt_s           = 8'd8;
        end
        CMD_SET_TIMER:  set_timer_s = ch_sel_s;
        CMD_RELEASE:    release_s   = ch_sel_s;
        CMD_SET_DIV:    set_div_s   = ch_sel_s;
        CMD_HALT:       halt_s      = ch_sel_s;
        CMD_GET_STATUS: begin
          rsp_nxt_s[N_CLK-1:0]     = en_r;
          rsp_nxt_s[32 +: N_CLK]   = pending_r;
          rsp_sz_nxt_s             = 8'd8;
        end
        default: rsp_sz_nxt_s = 8'd0;
      endcase
    end else begin
      rsp_sz_nxt_s = 8'd0;
    end
  end

  // Tick, rising-edge and expiry detection from the pre-edge state.
  // A SetTimer on the same edge overrides the decrement, so it suppresses expiry.
  always_comb begin
    tick_s   = '0;
    rise_s   = '0;
    expire_s = '0;
    for (int i = 0; i < N_CLK; i++) begin
      tick_s[i]   = en_r[i] & (div_cnt_r[i] == div_r[i]);
      rise_s[i]   = tick_s[i] & ~cclock_r[i];
      expire_s[i] = rise_s[i] & (timer_r[i] == TIMER_W'(1)) & ~set_timer_s[i];
    end
  end

  // Per-channel clock, divider, counter, timer and enable registers
  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      en_r     <= '0;
      cclock_r <= '0;
      for (int i = 0; i < N_CLK; i++) begin
        div_r[i]     <= '0;
        div_cnt_r[i] <= '0;
        timer_r[i]   <= '0;
        count_r[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_CLK; i++) begin
        // The divider is free-running against div; lowering div below the
        // current count lets it wrap through 2^TIMER_W before the next tick.
        if (tick_s[i]) begin
          cclock_r[i]  <= ~cclock_r[i];
          div_cnt_r[i] <= '0;
        end else if (en_r[i]) begin
          div_cnt_r[i] <= div_cnt_r[i] + TIMER_W'(1);
        end else begin
          div_cnt_r[i] <= '0;
        end

        if (rise_s[i]) begin
          count_r[i] <= count_r[i] + COUNT_W'(1);
        end

        if (set_timer_s[i]) begin
          timer_r[i] <= val_s;
        end else if (rise_s[i] && (timer_r[i] != '0)) begin
          timer_r[i] <= timer_r[i] - TIMER_W'(1);
        end

        if (set_div_s[i]) begin
          div_r[i] <= val_s;
        end

        // Expiry halt beats a same-edge Release; Halt never blocks the toggle
        // because tick_s was already computed from the old enable.
        if (expire_s[i] && HALT_ON_TIMER) begin
          en_r[i] <= 1'b0;
        end else if (halt_s[i]) begin
          en_r[i] <= 1'b0;
        end else if (release_s[i]) begin
          en_r[i] <= 1'b1;
        end
      end
    end
  end

  // Command handshake: response and get toggle land on the same edge
  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      get_r    <= 1'b0;
      rsp_r    <= '0;
      rsp_sz_r <= 8'd0;
    end else if (cmd_hit_s) begin
      get_r    <= ~get_r;
      rsp_r    <= rsp_nxt_s;
      rsp_sz_r <= rsp_sz_nxt_s;
    end
  end

  // Lowest pending channel: isolated bit for clearing, index for the event
  always_comb begin
    lowest_s   = pending_r & (~pending_r + N_CLK'(1));
    post_idx_s = 8'd0;
    for (int i = N_CLK - 1; i >= 0; i--) begin
      post_idx_s = pending_r[i] ? 8'(i) : post_idx_s;
    end
  end

  // Event FSM next state: post in IDLE, wait for the host to echo the toggle
  always_comb begin
    state_nxt_s = state_r;
    post_s      = 1'b0;
    post_clr_s  = '0;
    case (state_r)
      ST_IDLE: begin
        if (|pending_r) begin
          post_s      = 1'b1;
          post_clr_s  = lowest_s;
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (put_r == cmd_out_get_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Event FSM state, posted event fields and the pending queue.
  // A same-edge expiry of the bit being posted re-arms it.
  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      put_r      <= 1'b0;
      ev_code_r  <= 8'd0;
      ev_sz_r    <= 8'd0;
      ev_param_r <= 8'd0;
      pending_r  <= '0;
    end else begin
      state_r   <= state_nxt_s;
      pending_r <= (pending_r & ~post_clr_s) | expire_s;
      if (post_s) begin
        put_r      <= ~put_r;
        ev_code_r  <= 8'd1;
        ev_sz_r    <= 8'd1;
        ev_param_r <= post_idx_s;
      end
    end
  end

  assign cclock         = cclock_r;
  assign cmd_in_get_i   = get_r;
  assign cmd_in_rsp     = rsp_r;
  assign cmd_in_rsp_sz  = rsp_sz_r;
  assign cmd_out        = ev_code_r;
  assign cmd_out_sz     = ev_sz_r;
  assign cmd_out_params = ev_param_r;
  assign cmd_out_put_i  = put_r;

endmodule

// File: tb/tb_tblink_rpc_clkctrl_mc.sv
// ---------------------------------------------------------------------------
// Bench for tblink_rpc_clkctrl_mc: directed scenarios plus randomized command
// traffic, checked each cycle against a behavioural model of the channels,
// the command responses and the event queue.
// ---------------------------------------------------------------------------
module tb_tblink_rpc_clkctrl_mc;

  localparam int N  = 4;
  localparam int CW = 64;
  localparam int TW = 32;
  localparam bit HALT = 1'b1;

  logic          uclock;
  logic          reset;
  logic [N-1:0]  cclock;
  logic [7:0]    cmd_in;
  logic [63:0]   cmd_in_params;
  logic          cmd_in_put_i;
  logic          cmd_in_get_i;
  logic [63:0]   cmd_in_rsp;
  logic [7:0]    cmd_in_rsp_sz;
  logic [7:0]    cmd_out;
  logic [7:0]    cmd_out_sz;
  logic [7:0]    cmd_out_params;
  logic          cmd_out_put_i;
  logic          cmd_out_get_i;

  int n_checks = 0;
  int n_errors = 0;
  bit hold_ack = 1'b0;
  logic [7:0] ev_q[$];

  tblink_rpc_clkctrl_mc #(
    .N_CLK(N), .COUNT_W(CW), .TIMER_W(TW), .HALT_ON_TIMER(HALT)
  ) dut (
    .uclock(uclock),
    .reset(reset),
    .cclock(cclock),
    .cmd_in(cmd_in),
    .cmd_in_params(cmd_in_params),
    .cmd_in_put_i(cmd_in_put_i),
    .cmd_in_get_i(cmd_in_get_i),
    .cmd_in_rsp(cmd_in_rsp),
    .cmd_in_rsp_sz(cmd_in_rsp_sz),
    .cmd_out(cmd_out),
    .cmd_out_sz(cmd_out_sz),
    .cmd_out_params(cmd_out_params),
    .cmd_out_put_i(cmd_out_put_i),
    .cmd_out_get_i(cmd_out_get_i)
  );

  initial begin
    uclock = 1'b0;
    forever #5 uclock = ~uclock;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [N-1:0]  m_en, m_cclk, m_pend;
  logic [TW-1:0] m_div[N], m_dcnt[N], m_tmr[N];
  logic [CW-1:0] m_cnt[N];
  logic          m_get, m_busy, m_put;
  logic [63:0]   m_rsp;
  logic [7:0]    m_sz, m_evc, m_evsz, m_evp;

  always @(posedge uclock or posedge reset) begin : model_blk
    logic hit, ok, mine, tick;
    logic [7:0] c_ch;
    logic [TW-1:0] c_v;
    logic [N-1:0] n_en, n_cclk, exp_m, clr_m;
    logic [TW-1:0] n_div[N], n_dcnt[N], n_tmr[N];
    logic [CW-1:0] n_cnt[N];
    logic [63:0] n_rsp;
    logic [7:0] n_sz, n_evp;
    logic n_busy, n_put;
    int k;
    if (reset) begin
      m_en <= '0; m_cclk <= '0; m_pend <= '0;
      m_get <= 1'b0; m_busy <= 1'b0; m_put <= 1'b0;
      m_rsp <= 64'd0; m_sz <= 8'd0; m_evc <= 8'd0; m_evsz <= 8'd0; m_evp <= 8'd0;
      for (int i = 0; i < N; i++) begin
        m_div[i] <= '0; m_dcnt[i] <= '0; m_tmr[i] <= '0; m_cnt[i] <= '0;
      end
    end else begin
      hit  = (cmd_in_put_i != m_get);
      c_ch = cmd_in_params[7:0];
      c_v  = cmd_in_params[8 +: TW];
      ok   = (c_ch < 8'(N));
      n_rsp = m_rsp;
      n_sz  = m_sz;
      if (hit) begin
        n_sz = 8'd0;
        if (ok && cmd_in == 8'd1) begin n_rsp = m_cnt[c_ch[1:0]]; n_sz = 8'd8; end
        if (ok && cmd_in == 8'd6) begin n_rsp = {28'd0, m_pend, 28'd0, m_en}; n_sz = 8'd8; end
      end
      exp_m = '0;
      for (int i = 0; i < N; i++) begin
        mine = hit && ok && (c_ch == 8'(i));
        n_en[i] = m_en[i]; n_cclk[i] = m_cclk[i];
        n_div[i] = m_div[i]; n_tmr[i] = m_tmr[i]; n_cnt[i] = m_cnt[i];
        tick = m_en[i] && (m_dcnt[i] == m_div[i]);
        if (tick) begin
          n_cclk[i] = !m_cclk[i];
          n_dcnt[i] = '0;
        end else begin
          n_dcnt[i] = m_en[i] ? m_dcnt[i] + 1 : '0;
        end
        if (tick && !m_cclk[i]) begin
          n_cnt[i] = m_cnt[i] + 1;
          if (m_tmr[i] != 0) begin
            n_tmr[i] = m_tmr[i] - 1;
            if (m_tmr[i] == 1) exp_m[i] = 1'b1;
          end
        end
        if (mine) begin
          case (cmd_in)
            8'd2: begin n_tmr[i] = c_v; exp_m[i] = 1'b0; end
            8'd3: n_en[i] = 1'b1;
            8'd4: n_div[i] = c_v;
            8'd5: n_en[i] = 1'b0;
            default: ;
          endcase
        end
        if (exp_m[i] && HALT) n_en[i] = 1'b0;
      end
      clr_m = '0; n_busy = m_busy; n_put = m_put; n_evp = m_evp;
      if (!m_busy) begin
        if (m_pend != 0) begin
          k = 0;
          for (int j = N - 1; j >= 0; j--) if (m_pend[j]) k = j;
          clr_m[k] = 1'b1;
          n_put = !m_put; n_evp = 8'(k); n_busy = 1'b1;
          m_evc <= 8'd1; m_evsz <= 8'd1;
        end
      end else if (m_put == cmd_out_get_i) begin
        n_busy = 1'b0;
      end
      m_pend <= (m_pend & ~clr_m) | exp_m;
      m_en <= n_en; m_cclk <= n_cclk;
      for (int i = 0; i < N; i++) begin
        m_div[i] <= n_div[i]; m_dcnt[i] <= n_dcnt[i]; m_tmr[i] <= n_tmr[i]; m_cnt[i] <= n_cnt[i];
      end
      m_get <= hit ? !m_get : m_get;
      m_rsp <= n_rsp; m_sz <= n_sz;
      m_busy <= n_busy; m_put <= n_put; m_evp <= n_evp;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge uclock) begin
    if (!reset) begin
      chk("cclock", 64'(cclock), 64'(m_cclk));
      chk("cmd_in_get_i", 64'(cmd_in_get_i), 64'(m_get));
      chk("cmd_in_rsp_sz", 64'(cmd_in_rsp_sz), 64'(m_sz));
      if (m_sz == 8'd8) chk("cmd_in_rsp", cmd_in_rsp, m_rsp);
      chk("cmd_out_put_i", 64'(cmd_out_put_i), 64'(m_put));
      chk("cmd_out", 64'(cmd_out), 64'(m_evc));
      chk("cmd_out_sz", 64'(cmd_out_sz), 64'(m_evsz));
      chk("cmd_out_params", 64'(cmd_out_params), 64'(m_evp));
    end
  end

  // Event monitor: record each posted channel index
  initial begin : mon_blk
    logic prev_put;
    prev_put = 1'b0;
    forever begin
      @(negedge uclock);
      if (reset) begin
        prev_put = 1'b0;
      end else if (cmd_out_put_i !== prev_put) begin
        prev_put = cmd_out_put_i;
        ev_q.push_back(cmd_out_params);
      end
    end
  end

  // Host side of the event handshake with random acceptance delay
  initial begin
    forever begin
      @(negedge uclock);
      if (!reset && !hold_ack && (cmd_out_put_i !== cmd_out_get_i)) begin
        repeat ($urandom_range(0, 3)) @(negedge uclock);
        if (!reset) cmd_out_get_i = cmd_out_put_i;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    cmd_in_put_i = 1'b0;
    cmd_out_get_i = 1'b0;
    cmd_in = 8'd0;
    cmd_in_params = 64'd0;
    repeat (2) @(negedge uclock);
    chk("rst_cclock", 64'(cclock), 64'd0);
    chk("rst_get", 64'(cmd_in_get_i), 64'd0);
    chk("rst_rsp", cmd_in_rsp, 64'd0);
    chk("rst_out_put", 64'(cmd_out_put_i), 64'd0);
    chk("rst_cmd_out", 64'(cmd_out), 64'd0);
    @(negedge uclock);
    reset = 1'b0;
    ev_q.delete();
  endtask

  // Present one command at a negedge; return at the negedge after it is served
  task automatic send_cmd(input logic [7:0] code, input logic [7:0] ch, input logic [31:0] v,
                          output logic [63:0] rsp, output logic [7:0] sz);
    int waited;
    cmd_in = code;
    cmd_in_params = {24'd0, v, ch};
    cmd_in_put_i = ~cmd_in_put_i;
    waited = 0;
    @(negedge uclock);
    while ((cmd_in_get_i !== cmd_in_put_i) && (waited < 20)) begin
      @(negedge uclock);
      waited++;
    end
    chk("cmd_latency", 64'(waited), 64'd0);
    rsp = cmd_in_rsp;
    sz = cmd_in_rsp_sz;
  endtask

  task automatic wait_ev(input int n, input int budget, input string name);
    int t;
    t = 0;
    while ((ev_q.size() < n) && (t < budget)) begin
      @(negedge uclock);
      t++;
    end
    chk(name, 64'(ev_q.size()), 64'(n));
  endtask

  logic [63:0] r;
  logic [7:0]  s;
  logic [7:0]  rc;

  initial begin
    reset = 1'b1;
    cmd_in_put_i = 1'b0;
    cmd_out_get_i = 1'b0;
    cmd_in = 8'd0;
    cmd_in_params = 64'd0;
    @(negedge uclock);
    do_reset();

    // Free-running ch0 at uclock/2; 20 edges give 10 rising edges
    send_cmd(8'd4, 8'd0, 32'd0, r, s);
    send_cmd(8'd3, 8'd0, 32'd0, r, s);
    repeat (20) @(negedge uclock);
    send_cmd(8'd1, 8'd0, 32'd0, r, s);
    chk("t1_gettime", r, 64'd10);
    chk("t1_sz", 64'(s), 64'd8);

    // ch1 div=2 timer=3: expires on 3rd rising edge, frozen high
    send_cmd(8'd4, 8'd1, 32'd2, r, s);
    chk("t2_setdiv_sz", 64'(s), 64'd0);
    send_cmd(8'd2, 8'd1, 32'd3, r, s);
    send_cmd(8'd3, 8'd1, 32'd0, r, s);
    wait_ev(1, 60, "t2_event_count");
    if (ev_q.size() > 0) chk("t2_ev_param", 64'(ev_q[0]), 64'd1);
    chk("t2_cmd_out", 64'(cmd_out), 64'd1);
    chk("t2_cmd_out_sz", 64'(cmd_out_sz), 64'd1);
    repeat (10) @(negedge uclock);
    chk("t2_frozen_high", 64'(cclock[1]), 64'd1);
    send_cmd(8'd6, 8'd0, 32'd0, r, s);
    chk("t2_status", r, 64'h1);

    // ch0 and ch2 expire back to back; second waits for the first ack
    do_reset();
    hold_ack = 1'b1;
    send_cmd(8'd4, 8'd0, 32'd1, r, s);
    send_cmd(8'd4, 8'd2, 32'd1, r, s);
    send_cmd(8'd2, 8'd0, 32'd2, r, s);
    send_cmd(8'd2, 8'd2, 32'd2, r, s);
    send_cmd(8'd3, 8'd0, 32'd0, r, s);
    send_cmd(8'd3, 8'd2, 32'd0, r, s);
    wait_ev(1, 40, "t3_first_event");
    repeat (20) @(negedge uclock);
    chk("t3_held", 64'(ev_q.size()), 64'd1);
    send_cmd(8'd6, 8'd0, 32'd0, r, s);
    chk("t3_status_held", r, 64'h0000_0004_0000_0000);
    hold_ack = 1'b0;
    wait_ev(2, 40, "t3_second_event");
    if (ev_q.size() >= 2) begin
      chk("t3_order0", 64'(ev_q[0]), 64'd0);
      chk("t3_order1", 64'(ev_q[1]), 64'd2);
    end
    repeat (10) @(negedge uclock);
    send_cmd(8'd6, 8'd0, 32'd0, r, s);
    chk("t3_status_end", r, 64'd0);

    // Halt on the tick edge: toggle still happens, then level holds
    do_reset();
    send_cmd(8'd4, 8'd0, 32'd0, r, s);
    send_cmd(8'd3, 8'd0, 32'd0, r, s);
    send_cmd(8'd5, 8'd0, 32'd0, r, s);
    repeat (10) @(negedge uclock);
    chk("t4_hold_level", 64'(cclock[0]), 64'd1);
    send_cmd(8'd1, 8'd0, 32'd0, r, s);
    chk("t4_count_halted", r, 64'd1);
    send_cmd(8'd3, 8'd0, 32'd0, r, s);
    repeat (4) @(negedge uclock);
    send_cmd(8'd1, 8'd0, 32'd0, r, s);
    chk("t4_count_resumed", r, 64'd3);

    // Illegal channel / unknown code
    send_cmd(8'd6, 8'd4, 32'd0, r, s);
    chk("t5_badch_sz", 64'(s), 64'd0);
    send_cmd(8'h7F, 8'd0, 32'd9, r, s);
    chk("t5_badcode_sz", 64'(s), 64'd0);
    send_cmd(8'd2, 8'd200, 32'd5, r, s);
    chk("t5_badtimer_sz", 64'(s), 64'd0);
    send_cmd(8'd6, 8'd0, 32'd0, r, s);
    chk("t5_status", r, 64'h1);

    // Reset with an event outstanding and a timer running
    hold_ack = 1'b1;
    send_cmd(8'd2, 8'd1, 32'd1, r, s);
    send_cmd(8'd3, 8'd1, 32'd0, r, s);
    send_cmd(8'd2, 8'd2, 32'd100, r, s);
    send_cmd(8'd3, 8'd2, 32'd0, r, s);
    repeat (5) @(negedge uclock);
    chk("t6_event_out", 64'(ev_q.size()), 64'd1);
    chk("t6_put_before", 64'(cmd_out_put_i), 64'd1);
    @(posedge uclock);
    #2;
    reset = 1'b1;
    cmd_in_put_i = 1'b0;
    cmd_out_get_i = 1'b0;
    #1;
    chk("t6_cclock_rst", 64'(cclock), 64'd0);
    chk("t6_put_rst", 64'(cmd_out_put_i), 64'd0);
    chk("t6_cmd_out_rst", 64'(cmd_out), 64'd0);
    repeat (2) @(negedge uclock);
    reset = 1'b0;
    hold_ack = 1'b0;
    ev_q.delete();
    send_cmd(8'd6, 8'd0, 32'd0, r, s);
    chk("t6_status_rst", r, 64'd0);
    chk("t6_status_sz", 64'(s), 64'd8);
    repeat (20) @(negedge uclock);
    chk("t6_no_events", 64'(ev_q.size()), 64'd0);

    // Randomized traffic
    for (int round = 0; round < 3; round++) begin
      do_reset();
      for (int n = 0; n < 150; n++) begin
        rc = 8'($urandom_range(0, 9));
        if (rc > 8'd7) rc = 8'h7F;
        hold_ack = ($urandom_range(0, 15) == 0);
        send_cmd(rc, 8'($urandom_range(0, 5)), 32'($urandom_range(0, 5)), r, s);
        repeat ($urandom_range(0, 4)) @(negedge uclock);
      end
      hold_ack = 1'b0;
      repeat (30) @(negedge uclock);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
